// File: rtl/dsp_counter_reader.sv
// Consumer for an acknowledge-mode DSP timed counter: captures each held count,
// acks the counter, streams the result with stall tagging and sequences interval reloads.
module dsp_counter_reader #(
    parameter logic [23:0] INIT_INTERVAL = 24'd1000,
    parameter int          ACK_HOLDOFF   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [24:0] count_i,
    input  logic        count_valid_i,
    output logic        count_ack_o,
    output logic        interval_load_o,
    output logic [23:0] interval_o,
    input  logic        interval_wr_i,
    input  logic [23:0] interval_wdata_i,
    output logic        interval_busy_o,
    output logic [47:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(ACK_HOLDOFF - 1);

    state_t      state_reg;
    logic        ack_reg;
    logic        load_reg;
    logic [23:0] interval_reg;
    logic [23:0] pending_reg;
    logic        busy_reg;
    logic [47:0] tdata_reg;
    logic        tvalid_reg;
    logic [15:0] dead_reg;
    logic [3:0]  holdoff_reg;

    logic buffer_free;
    assign buffer_free = !tvalid_reg || m_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset lands in LOAD so the counter is re-armed on the first free cycle.
            state_reg    <= LOAD;
            ack_reg      <= 1'b0;
            load_reg     <= 1'b0;
            interval_reg <= INIT_INTERVAL;
            pending_reg  <= INIT_INTERVAL;
            busy_reg     <= 1'b0;
            tdata_reg    <= 48'd0;
            tvalid_reg   <= 1'b0;
            dead_reg     <= 16'd0;
            holdoff_reg  <= 4'd0;
        end else begin
            ack_reg  <= 1'b0;
            load_reg <= 1'b0;

            if (tvalid_reg && m_tready) begin
                tvalid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (count_valid_i && buffer_free) begin
                        tdata_reg   <= {dead_reg, 7'b0, count_i};
                        tvalid_reg  <= 1'b1;
                        ack_reg     <= 1'b1;
                        dead_reg    <= 16'd0;
                        holdoff_reg <= 4'd0;
                        state_reg   <= CLEAR;
                    end else if (count_valid_i) begin
                        if (dead_reg != 16'hFFFF) begin
                            dead_reg <= dead_reg + 16'd1;
                        end
                    end else if (busy_reg) begin
                        state_reg <= LOAD;
                    end
                end

                LOAD: begin
                    interval_reg <= pending_reg;
                    load_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                    holdoff_reg  <= 4'd0;
                    state_reg    <= CLEAR;
                end

                CLEAR: begin
                    // The counter's flag lags the ack by a cycle; ignore it until holdoff expires.
                    if (holdoff_reg != 4'hF) begin
                        holdoff_reg <= holdoff_reg + 4'd1;
                    end
                    if (holdoff_reg >= HOLD_LAST && !count_valid_i) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= LOAD;
                end
            endcase

            // Placed after the state logic so a write coinciding with LOAD stays pending.
            if (interval_wr_i) begin
                pending_reg <= interval_wdata_i;
                busy_reg    <= 1'b1;
            end
        end
    end

    assign count_ack_o     = ack_reg;
    assign interval_load_o = load_reg;
    assign interval_o      = interval_reg;
    assign interval_busy_o = busy_reg;
    assign m_tdata         = tdata_reg;
    assign m_tvalid        = tvalid_reg;

endmodule

// File: tb/tb_dsp_counter_reader.sv
// Directed bench for dsp_counter_reader: reset, capture, backpressure, interval sequencing,
// saturation and mid-operation reset, each with hand-computed expectations.
module tb_dsp_counter_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] count_i;
    logic        count_valid_i;
    logic        count_ack_o;
    logic        interval_load_o;
    logic [23:0] interval_o;
    logic        interval_wr_i;
    logic [23:0] interval_wdata_i;
    logic        interval_busy_o;
    logic [47:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;

    int checks = 0;
    int fails  = 0;
    int ack_count = 0;
    int load_count = 0;
    int overlap = 0;
    logic [23:0] last_load_val = 24'd0;

    always #5 clk = ~clk;

    dsp_counter_reader #(
        .INIT_INTERVAL(24'd1000),
        .ACK_HOLDOFF(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .count_i(count_i),
        .count_valid_i(count_valid_i),
        .count_ack_o(count_ack_o),
        .interval_load_o(interval_load_o),
        .interval_o(interval_o),
        .interval_wr_i(interval_wr_i),
        .interval_wdata_i(interval_wdata_i),
        .interval_busy_o(interval_busy_o),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready)
    );

    always @(negedge clk) begin
        if (count_ack_o === 1'b1) ack_count++;
        if (interval_load_o === 1'b1) begin
            load_count++;
            last_load_val = interval_o;
        end
        if (count_ack_o === 1'b1 && interval_load_o === 1'b1) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; count_i = '0; count_valid_i = 1'b0; interval_wr_i = 1'b0;
        interval_wdata_i = '0; m_tready = 1'b0;
        repeat (5) tick();
        checks++; if (interval_load_o !== 1'b0) begin fails++; $display("FAIL reset_load: got %0b expected 0", interval_load_o); end
        checks++; if (count_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack: got %0b expected 0", count_ack_o); end
        checks++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %0b expected 0", m_tvalid); end
        checks++; if (m_tdata !== 48'd0) begin fails++; $display("FAIL reset_tdata: got %h expected 0", m_tdata); end
        checks++; if (interval_busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", interval_busy_o); end
        checks++; if (interval_o !== 24'd1000) begin fails++; $display("FAIL reset_interval: got %0d expected 1000", interval_o); end
        rst = 1'b0;
        tick();
        checks++; if (interval_load_o !== 1'b1) begin fails++; $display("FAIL exit_load_pulse: got %0b expected 1", interval_load_o); end
        checks++; if (interval_o !== 24'd1000) begin fails++; $display("FAIL exit_load_value: got %0d expected 1000", interval_o); end
        tick();
        checks++; if (interval_load_o !== 1'b0) begin fails++; $display("FAIL exit_load_width: got %0b expected 0", interval_load_o); end
        checks++; if (m_tvalid !== 1'b0 || count_ack_o !== 1'b0) begin fails++; $display("FAIL exit_quiet: got tvalid=%0b ack=%0b expected 0/0", m_tvalid, count_ack_o); end
        repeat (3) tick();
        $display("reset release: load of %0d issued", last_load_val);
    endtask

    task automatic test_single_capture();
        int a0;
        a0 = ack_count;
        count_i = 25'd742; count_valid_i = 1'b1; m_tready = 1'b1;
        tick();
        checks++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL single_tvalid: got %0b expected 1", m_tvalid); end
        checks++; if (m_tdata !== 48'd742) begin fails++; $display("FAIL single_tdata: got %h expected %h", m_tdata, 48'd742); end
        checks++; if (count_ack_o !== 1'b1) begin fails++; $display("FAIL single_ack: got %0b expected 1", count_ack_o); end
        tick();
        checks++; if (count_ack_o !== 1'b0) begin fails++; $display("FAIL single_ack_width: got %0b expected 0", count_ack_o); end
        checks++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL single_drain: got %0b expected 0", m_tvalid); end
        count_valid_i = 1'b0;
        repeat (3) tick();
        checks++; if (ack_count - a0 !== 1) begin fails++; $display("FAIL single_ack_count: got %0d expected 1", ack_count - a0); end
        $display("capture: count=742 dead=0");
    endtask

    task automatic test_back_to_back();
        int a0;
        a0 = ack_count;
        m_tready = 1'b1; count_i = 25'd11; count_valid_i = 1'b1;
        tick();
        checks++; if (count_ack_o !== 1'b1 || m_tdata !== 48'd11) begin fails++; $display("FAIL b2b_first: got ack=%0b tdata=%h expected 1/%h", count_ack_o, m_tdata, 48'd11); end
        count_valid_i = 1'b0;
        tick();
        tick();
        checks++; if (ack_count - a0 !== 1) begin fails++; $display("FAIL b2b_gap: got %0d acks expected 1", ack_count - a0); end
        count_i = 25'd12; count_valid_i = 1'b1;
        tick();
        checks++; if (count_ack_o !== 1'b1 || m_tdata !== 48'd12) begin fails++; $display("FAIL b2b_second: got ack=%0b tdata=%h expected 1/%h", count_ack_o, m_tdata, 48'd12); end
        count_i = 25'd99;
        repeat (3) tick();
        checks++; if (ack_count - a0 !== 2) begin fails++; $display("FAIL b2b_clear_ignores_valid: got %0d acks expected 2", ack_count - a0); end
        count_valid_i = 1'b0;
        tick();
        count_i = 25'd13; count_valid_i = 1'b1;
        tick();
        checks++; if (count_ack_o !== 1'b1 || m_tdata !== 48'd13) begin fails++; $display("FAIL b2b_third: got ack=%0b tdata=%h expected 1/%h", count_ack_o, m_tdata, 48'd13); end
        count_valid_i = 1'b0;
        repeat (3) tick();
        $display("back-to-back: counts 11,12,13 captured");
    endtask

    task automatic test_backpressure();
        int a0;
        a0 = ack_count;
        m_tready = 1'b0; count_i = 25'd100; count_valid_i = 1'b1;
        tick();
        checks++; if (m_tdata !== 48'd100 || m_tvalid !== 1'b1) begin fails++; $display("FAIL bp_first: got tvalid=%0b tdata=%h expected 1/%h", m_tvalid, m_tdata, 48'd100); end
        count_valid_i = 1'b0;
        tick();
        tick();
        count_i = 25'd200; count_valid_i = 1'b1;
        repeat (10) tick();
        checks++; if (m_tdata !== 48'd100 || count_ack_o !== 1'b0) begin fails++; $display("FAIL bp_hold: got tdata=%h ack=%0b expected %h/0", m_tdata, count_ack_o, 48'd100); end
        m_tready = 1'b1;
        tick();
        checks++; if (m_tdata !== {16'd10, 7'd0, 25'd200} || m_tvalid !== 1'b1) begin fails++; $display("FAIL bp_second: got tvalid=%0b tdata=%h expected 1/%h", m_tvalid, m_tdata, {16'd10, 7'd0, 25'd200}); end
        checks++; if (count_ack_o !== 1'b1) begin fails++; $display("FAIL bp_second_ack: got %0b expected 1", count_ack_o); end
        count_valid_i = 1'b0;
        tick();
        checks++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %0b expected 0", m_tvalid); end
        tick();
        tick();
        checks++; if (ack_count - a0 !== 2) begin fails++; $display("FAIL bp_ack_count: got %0d expected 2", ack_count - a0); end
        $display("capture: count=200 dead=10");
    endtask

    task automatic test_interval_change();
        int n;
        m_tready = 1'b1; count_i = 25'd55; count_valid_i = 1'b1;
        interval_wr_i = 1'b1; interval_wdata_i = 24'd500;
        tick();
        checks++; if (count_ack_o !== 1'b1 || interval_load_o !== 1'b0) begin fails++; $display("FAIL ic_capture_first: got ack=%0b load=%0b expected 1/0", count_ack_o, interval_load_o); end
        checks++; if (interval_busy_o !== 1'b1) begin fails++; $display("FAIL ic_busy_set: got %0b expected 1", interval_busy_o); end
        interval_wr_i = 1'b0;
        tick();
        checks++; if (interval_load_o !== 1'b0 || interval_busy_o !== 1'b1) begin fails++; $display("FAIL ic_wait: got load=%0b busy=%0b expected 0/1", interval_load_o, interval_busy_o); end
        count_valid_i = 1'b0;
        n = 0;
        while (n < 10 && interval_load_o !== 1'b1) begin
            tick();
            n++;
        end
        checks++; if (n !== 3) begin fails++; $display("FAIL ic_load_latency: got %0d cycles expected 3", n); end
        checks++; if (interval_o !== 24'd500) begin fails++; $display("FAIL ic_load_value: got %0d expected 500", interval_o); end
        checks++; if (interval_busy_o !== 1'b0) begin fails++; $display("FAIL ic_busy_clear: got %0b expected 0", interval_busy_o); end
        repeat (3) tick();
        $display("interval load: %0d", interval_o);
    endtask

    task automatic test_last_write_wins();
        int l0;
        l0 = load_count;
        m_tready = 1'b0; count_i = 25'd7; count_valid_i = 1'b1;
        tick();
        count_valid_i = 1'b0;
        tick();
        tick();
        count_i = 25'd8; count_valid_i = 1'b1;
        interval_wr_i = 1'b1; interval_wdata_i = 24'd300;
        tick();
        interval_wdata_i = 24'd400;
        tick();
        interval_wr_i = 1'b0;
        tick();
        tick();
        checks++; if (interval_busy_o !== 1'b1 || load_count !== l0) begin fails++; $display("FAIL lww_pending: got busy=%0b loads=%0d expected 1/%0d", interval_busy_o, load_count, l0); end
        checks++; if (m_tdata !== 48'd7) begin fails++; $display("FAIL lww_stalled_data: got %h expected %h", m_tdata, 48'd7); end
        m_tready = 1'b1;
        tick();
        checks++; if (m_tdata !== {16'd4, 7'd0, 25'd8}) begin fails++; $display("FAIL lww_capture: got %h expected %h", m_tdata, {16'd4, 7'd0, 25'd8}); end
        count_valid_i = 1'b0;
        repeat (8) tick();
        checks++; if (load_count - l0 !== 1) begin fails++; $display("FAIL lww_load_count: got %0d expected 1", load_count - l0); end
        checks++; if (last_load_val !== 24'd400 || interval_o !== 24'd400) begin fails++; $display("FAIL lww_value: got load=%0d interval=%0d expected 400", last_load_val, interval_o); end
        checks++; if (interval_busy_o !== 1'b0) begin fails++; $display("FAIL lww_busy: got %0b expected 0", interval_busy_o); end
        $display("capture: count=8 dead=4, interval load: %0d", last_load_val);
    endtask

    task automatic test_saturation_reset();
        int l0;
        m_tready = 1'b0; count_i = 25'd9; count_valid_i = 1'b1;
        tick();
        count_valid_i = 1'b0;
        tick();
        tick();
        count_i = 25'd21; count_valid_i = 1'b1;
        repeat (70000) tick();
        m_tready = 1'b1;
        tick();
        checks++; if (m_tdata[47:32] !== 16'hFFFF || m_tdata[24:0] !== 25'd21) begin fails++; $display("FAIL sat_dead: got dead=%h count=%0d expected ffff/21", m_tdata[47:32], m_tdata[24:0]); end
        m_tready = 1'b0; count_valid_i = 1'b0;
        tick();
        tick();
        count_i = 25'd22; count_valid_i = 1'b1;
        interval_wr_i = 1'b1; interval_wdata_i = 24'd123;
        tick();
        interval_wr_i = 1'b0;
        tick();
        tick();
        checks++; if (interval_busy_o !== 1'b1 || m_tvalid !== 1'b1) begin fails++; $display("FAIL rst_pre: got busy=%0b tvalid=%0b expected 1/1", interval_busy_o, m_tvalid); end
        rst = 1'b1;
        tick();
        checks++; if (m_tvalid !== 1'b0 || m_tdata !== 48'd0) begin fails++; $display("FAIL rst_drop: got tvalid=%0b tdata=%h expected 0/0", m_tvalid, m_tdata); end
        checks++; if (interval_busy_o !== 1'b0 || interval_o !== 24'd1000) begin fails++; $display("FAIL rst_interval: got busy=%0b interval=%0d expected 0/1000", interval_busy_o, interval_o); end
        checks++; if (count_ack_o !== 1'b0 || interval_load_o !== 1'b0) begin fails++; $display("FAIL rst_pulses: got ack=%0b load=%0b expected 0/0", count_ack_o, interval_load_o); end
        count_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        l0 = load_count;
        tick();
        checks++; if (interval_load_o !== 1'b1 || interval_o !== 24'd1000) begin fails++; $display("FAIL rst_reload: got load=%0b interval=%0d expected 1/1000", interval_load_o, interval_o); end
        repeat (4) tick();
        checks++; if (load_count - l0 !== 1 || last_load_val !== 24'd1000) begin fails++; $display("FAIL rst_single_reload: got loads=%0d value=%0d expected 1/1000", load_count - l0, last_load_val); end
        $display("saturation: dead=ffff, reset reload: %0d", last_load_val);
    endtask

    task automatic test_exclusive();
        checks++; if (overlap !== 0) begin fails++; $display("FAIL ack_load_overlap: got %0d cycles expected 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_back_to_back();
        test_backpressure();
        test_interval_change();
        test_last_write_wins();
        test_saturation_reset();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
